// File: rtl/load_store_unit.sv
// RV32I load/store unit between execute and a word-wide data memory.
// Sub-word stores are a read-modify-write of the containing word; one request in flight at a time.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {StIdle, StLoad, StStore, StRmwRd, StRmwWr} state_e;

  localparam logic [32:0] MemBytes = 33'(MEM_WORDS) * 33'd4;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, merge_q, merge_d, load_data;
  logic [2:0]  funct3_q;
  logic        accept, illegal, out_of_range, misaligned, req_err;
  logic        resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;

  always_comb begin
    illegal      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_is_store && req_funct3[2]);
    out_of_range = {1'b0, req_addr} >= MemBytes;
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err      = illegal || out_of_range || misaligned;
  end

  // Lane selection for loads and the sub-word merge of the RMW read.
  always_comb begin
    ld_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_read_data[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = mem_read_data;
    endcase
    merge_d = mem_read_data;
    if (funct3_q[0]) begin
      merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = resp_err;
    resp_rdata_d   = resp_rdata;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = 32'h0;
    mem_addr       = (state_q == StIdle) ? 32'h0 : {addr_q[31:2], 2'b00};
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (!req_is_store) begin
            state_d = StLoad;
          end else if (req_funct3[1]) begin
            state_d = StStore;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        mem_read     = 1'b1;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_data;
        state_d      = StIdle;
      end
      StStore: begin
        mem_write      = 1'b1;
        mem_write_data = wdata_q;
        resp_valid_d   = 1'b1;
        resp_err_d     = 1'b0;
        resp_rdata_d   = 32'h0;
        state_d        = StIdle;
      end
      StRmwRd: begin
        mem_read = 1'b1;
        state_d  = StRmwWr;
      end
      StRmwWr: begin
        mem_write      = 1'b1;
        mem_write_data = merge_q;
        resp_valid_d   = 1'b1;
        resp_err_d     = 1'b0;
        resp_rdata_d   = 32'h0;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      funct3_q   <= 3'b000;
      merge_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
      if (state_q == StRmwRd) begin
        merge_q <= merge_d;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 256-word memory model plus hand-computed
// expected responses, memory words and strobe counts.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_val = 32'h0;
  int          rd_cnt = 0, wr_cnt = 0, rd_base, wr_base;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_read_data (mem_read_data)
  );

  assign mem_read_data = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_write_data;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  always @(negedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    tick();
    pl_en = 1'b0;
  endtask

  // Presents a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    chk("ready_at_issue", {31'h0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    tick();
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, {31'h0, resp_err}, 32'h0);
  endtask

  task automatic err_chk(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a);
    rd_base = rd_cnt; wr_base = wr_cnt;
    issue(st, f3, a, 32'hFFFF_FFFF);
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_err"}, {31'h0, resp_err}, 32'h1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    tick();
    chk({tag, "_valid_drop"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_no_strobe"}, 32'(rd_cnt - rd_base + wr_cnt - wr_base), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    tick(); tick();
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    rst = 1'b0;

    // Word load with latency and strobe count.
    poke(8'd4, 32'hDEAD_BEEF);
    rd_base = rd_cnt; wr_base = wr_cnt;
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_c1_read", {31'h0, mem_read}, 32'h1);
    chk("lw_c1_addr", mem_addr, 32'h10);
    chk("lw_c1_ready", {31'h0, req_ready}, 32'h0);
    chk("lw_c1_valid", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("lw_valid", {31'h0, resp_valid}, 32'h1);
    chk("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("lw_err", {31'h0, resp_err}, 32'h0);
    tick();
    chk("lw_pulse", {31'h0, resp_valid}, 32'h0);
    chk("lw_hold", resp_rdata, 32'hDEAD_BEEF);
    chk("lw_reads", 32'(rd_cnt - rd_base), 32'h1);
    chk("lw_writes", 32'(wr_cnt - wr_base), 32'h0);

    // Sub-word loads and extension.
    poke(8'd4, 32'h80AA_BBCC);
    load_chk("lb", 3'b000, 32'h13, 32'hFFFF_FF80);
    load_chk("lbu", 3'b100, 32'h13, 32'h0000_0080);
    load_chk("lh", 3'b001, 32'h12, 32'hFFFF_80AA);
    load_chk("lhu", 3'b101, 32'h10, 32'h0000_BBCC);
    tick();

    // Read-modify-write stores.
    poke(8'd4, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h11, 32'h0000_005A);
    chk("sb_c1_read", {31'h0, mem_read}, 32'h1);
    chk("sb_c1_write", {31'h0, mem_write}, 32'h0);
    tick();
    chk("sb_c2_write", {31'h0, mem_write}, 32'h1);
    chk("sb_c2_wdata", mem_write_data, 32'h1122_5A44);
    chk("sb_c2_addr", mem_addr, 32'h10);
    chk("sb_c2_valid", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("sb_c3_valid", {31'h0, resp_valid}, 32'h1);
    chk("sb_c3_err", {31'h0, resp_err}, 32'h0);
    chk("sb_mem", mem[4], 32'h1122_5A44);
    issue(1'b1, 3'b001, 32'h12, 32'h0000_BEEF);
    tick();
    chk("sh_wdata", mem_write_data, 32'hBEEF_5A44);
    tick();
    chk("sh_valid", {31'h0, resp_valid}, 32'h1);
    chk("sh_mem", mem[4], 32'hBEEF_5A44);

    // Errors: leave nonzero rdata first so the zeroing is visible.
    load_chk("lw_pre", 3'b010, 32'h10, 32'hBEEF_5A44);
    err_chk("sh_misal", 1'b1, 3'b001, 32'h21);
    err_chk("lw_misal", 1'b0, 3'b010, 32'h22);
    err_chk("f3_011", 1'b0, 3'b011, 32'h10);
    err_chk("st_f3_100", 1'b1, 3'b100, 32'h10);
    err_chk("sw_range", 1'b1, 3'b010, 32'h400);

    // Last in-range word.
    issue(1'b1, 3'b010, 32'h3FC, 32'hCAFE_F00D);
    chk("sw_top_write", {31'h0, mem_write}, 32'h1);
    chk("sw_top_addr", mem_addr, 32'h3FC);
    chk("sw_top_wdata", mem_write_data, 32'hCAFE_F00D);
    tick();
    chk("sw_top_valid", {31'h0, resp_valid}, 32'h1);
    chk("sw_top_err", {31'h0, resp_err}, 32'h0);
    chk("sw_top_mem", mem[255], 32'hCAFE_F00D);

    // Reset during RMW_RD drops the store.
    rd_base = rd_cnt; wr_base = wr_cnt;
    issue(1'b1, 3'b000, 32'h10, 32'h0000_0077);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mid_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    tick();
    chk("rst_mid_valid2", {31'h0, resp_valid}, 32'h0);
    chk("rst_mid_mem", mem[4], 32'hBEEF_5A44);
    chk("rst_mid_writes", 32'(wr_cnt - wr_base), 32'h0);

    // Back-to-back loads: second accepted in the first response cycle.
    poke(8'd1, 32'h0102_0304);
    poke(8'd2, 32'h0A0B_0C0D);
    issue(1'b0, 3'b010, 32'h04, 32'h0);
    tick();
    chk("b2b_r1_valid", {31'h0, resp_valid}, 32'h1);
    chk("b2b_r1_rdata", resp_rdata, 32'h0102_0304);
    issue(1'b0, 3'b010, 32'h08, 32'h0);
    chk("b2b_c3_valid", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("b2b_r2_valid", {31'h0, resp_valid}, 32'h1);
    chk("b2b_r2_rdata", resp_rdata, 32'h0A0B_0C0D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
